// File: rtl/decoder_pipe_pkg.sv
// Shared types and helpers for the decoder_pipe slice.
// Holds the skid-buffer state encoding and the parity helper used by the top.
package decoder_pipe_pkg;

  // Skid buffer occupancy: nothing, output register only, output plus skid.
  // The encoding 2'd3 is never produced and falls back to EMPTY behaviour.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skidState_e;

  localparam int STATE_W = 2;

  // True when the XOR of all bits is zero, i.e. the word has even parity.
  function automatic logic evenParityOk(input logic [31:0] word, input int width);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < width; i++) begin
      acc = acc ^ word[i];
    end
    return !acc;
  endfunction

endpackage

// File: rtl/decoder_skid.sv
// Generic 2-entry valid/ready skid buffer.
// in_ready_o comes straight from the state register, so there is no
// combinational path from either valid or ready input to the upstream ready.
// Entries are emitted in arrival order; a word is never dropped or repeated.
module decoder_skid
  import decoder_pipe_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  skidState_e       state_q, state_d;
  logic [WIDTH-1:0] outData_q, outData_d;
  logic [WIDTH-1:0] skidData_q, skidData_d;
  logic             accept;
  logic             deliver;

  assign in_ready_o  = (state_q != ST_FULL);
  assign out_valid_o = (state_q == ST_ONE) || (state_q == ST_FULL);
  assign out_data_o  = outData_q;
  assign accept      = in_valid_i && in_ready_o;
  assign deliver     = out_valid_o && out_ready_i;

  // Next-state and data-movement logic for the three occupancy levels.
  always_comb begin
    state_d    = state_q;
    outData_d  = outData_q;
    skidData_d = skidData_q;
    unique case (state_q)
      ST_ONE: begin
        if (accept && !deliver) begin
          state_d    = ST_FULL;
          skidData_d = in_data_i;
        end else if (accept && deliver) begin
          state_d   = ST_ONE;
          outData_d = in_data_i;
        end else if (deliver) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (deliver) begin
          state_d   = ST_ONE;
          outData_d = skidData_q;
        end
      end
      default: begin
        // EMPTY, and the unreachable encoding which recovers as EMPTY.
        state_d = ST_EMPTY;
        if (accept) begin
          state_d   = ST_ONE;
          outData_d = in_data_i;
        end
      end
    endcase
  end

  // State and storage registers; reset discards both entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      outData_q  <= '0;
      skidData_q <= '0;
    end else begin
      state_q    <= state_d;
      outData_q  <= outData_d;
      skidData_q <= skidData_d;
    end
  end

endmodule

// File: rtl/decoder_pipe.sv
// Registered binary-to-one-hot decoder with valid/ready on both sides.
// Decoding happens at accept; the decoded word rides through a 2-entry skid
// buffer. A saturating counter tracks output handshakes since reset.
// Optional feature macro: DECODER_PIPE_PARITY_EN adds in_par/out_err and an
// even-parity check over {in_par, in_code}; bad words travel as out_hot=0
// with out_err=1 in the same entry.
module decoder_pipe
  import decoder_pipe_pkg::*;
#(
  parameter  int IN_W  = 2,
  parameter  int CNT_W = 16,
  localparam int OUT_W = 1 << IN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_code,
`ifdef DECODER_PIPE_PARITY_EN
  input  logic             in_par,
  output logic             out_err,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_hot,
  output logic [CNT_W-1:0] out_cnt
);

`ifdef DECODER_PIPE_PARITY_EN
  localparam int ENTRY_W = OUT_W + 1;
`else
  localparam int ENTRY_W = OUT_W;
`endif

  logic [OUT_W-1:0]   decodedHot;
  logic [ENTRY_W-1:0] entryIn;
  logic [ENTRY_W-1:0] entryOut;
  logic               skidValid;
  logic               deliver;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  assign decodedHot = {{(OUT_W-1){1'b0}}, 1'b1} << in_code;

`ifdef DECODER_PIPE_PARITY_EN
  logic parityGood;
  assign parityGood = evenParityOk(32'({in_par, in_code}), IN_W + 1);
  assign entryIn    = parityGood ? {1'b0, decodedHot} : {1'b1, {OUT_W{1'b0}}};
  assign out_err    = skidValid && entryOut[OUT_W];
`else
  assign entryIn = decodedHot;
`endif

  decoder_skid #(
    .WIDTH(ENTRY_W)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (entryIn),
    .out_valid_o(skidValid),
    .out_ready_i(out_ready),
    .out_data_o (entryOut)
  );

  assign out_valid = skidValid;
  assign out_hot   = skidValid ? entryOut[OUT_W-1:0] : '0;
  assign deliver   = skidValid && out_ready;
  assign out_cnt   = cnt_q;

  // Count output handshakes, holding at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (deliver && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_decoder_pipe.sv
// Self-checking bench for decoder_pipe (CNT_W=4 so saturation is reachable).
// A 2-deep queue of expected words serves as the reference; each cycle the
// DUT outputs are compared mid-cycle against the queue head and counters.
// With DECODER_PIPE_PARITY_EN defined, the parity ports and checks are added.
module tb_decoder_pipe;

  localparam int IN_W  = 2;
  localparam int OUT_W = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_code;
  logic             in_par;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_hot;
  logic [CNT_W-1:0] out_cnt;
  logic             out_err;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: queue of {err, hot} words plus a saturating counter.
  logic [OUT_W:0] modelQ[$];
  int             modelCnt;

  always #5 clk = ~clk;

  decoder_pipe #(
    .IN_W (IN_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_code  (in_code),
`ifdef DECODER_PIPE_PARITY_EN
    .in_par   (in_par),
    .out_err  (out_err),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_hot  (out_hot),
    .out_cnt  (out_cnt)
  );

`ifndef DECODER_PIPE_PARITY_EN
  assign out_err = 1'b0;
`endif

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compareAll(input string tag);
    logic [OUT_W:0] head;
    head = (modelQ.size() > 0) ? modelQ[0] : '0;
    checkOutput({tag, ".in_ready"},  16'(in_ready),  16'(modelQ.size() < 2));
    checkOutput({tag, ".out_valid"}, 16'(out_valid), 16'(modelQ.size() > 0));
    checkOutput({tag, ".out_hot"},   16'(out_hot),   16'(head[OUT_W-1:0]));
    checkOutput({tag, ".out_cnt"},   16'(out_cnt),   16'(modelCnt));
`ifdef DECODER_PIPE_PARITY_EN
    checkOutput({tag, ".out_err"},   16'(out_err),   16'(head[OUT_W]));
`endif
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic applyStimulus(input string tag, input logic v, input logic [IN_W-1:0] c,
                               input logic p, input logic r);
    logic acc, del, bad;
    logic [OUT_W:0] word;
    in_valid  = v;
    in_code   = c;
    in_par    = p;
    out_ready = r;
    #3;
    compareAll(tag);
    acc = v && (modelQ.size() < 2);
    del = r && (modelQ.size() > 0);
`ifdef DECODER_PIPE_PARITY_EN
    bad = (($countones({p, c}) % 2) != 0);
`else
    bad = 1'b0;
`endif
    word = bad ? {1'b1, 4'b0000} : {1'b0, 4'(1 << int'(c))};
    @(posedge clk);
    #1;
    if (del) begin
      void'(modelQ.pop_front());
      if (modelCnt < 15) modelCnt++;
    end
    if (acc) modelQ.push_back(word);
  endtask

  task automatic doReset(input int cycles);
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_code   = '0;
    in_par    = 1'b0;
    out_ready = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    modelQ.delete();
    modelCnt = 0;
  endtask

  initial begin
    $display("[TB] start");
    modelCnt = 0;

    // Reset state.
    doReset(2);
    applyStimulus("reset", 1'b0, 2'd0, 1'b0, 1'b1);

    // Codes 0..3 back-to-back with the sink always ready.
    for (int i = 0; i < 4; i++) begin
      applyStimulus("stream", 1'b1, 2'(i), ^2'(i), 1'b1);
    end
    applyStimulus("stream_drain", 1'b0, 2'd0, 1'b0, 1'b1);
    applyStimulus("stream_cnt", 1'b0, 2'd0, 1'b0, 1'b1);
    checkOutput("stream_total", 16'(out_cnt), 16'd4);

    // Backpressure: fill both entries, hold, then drain.
    applyStimulus("bp_acc2", 1'b1, 2'd2, 1'b1, 1'b0);
    applyStimulus("bp_acc3", 1'b1, 2'd3, 1'b0, 1'b0);
    applyStimulus("bp_full", 1'b1, 2'd1, 1'b1, 1'b0);
    applyStimulus("bp_hold", 1'b0, 2'd0, 1'b0, 1'b0);
    applyStimulus("bp_drain1", 1'b0, 2'd0, 1'b0, 1'b1);
    applyStimulus("bp_drain2", 1'b0, 2'd0, 1'b0, 1'b1);
    applyStimulus("bp_empty", 1'b0, 2'd0, 1'b0, 1'b1);

    // Reset while FULL: queued words must never appear.
    applyStimulus("rf_acc2", 1'b1, 2'd2, 1'b1, 1'b0);
    applyStimulus("rf_acc3", 1'b1, 2'd3, 1'b0, 1'b0);
    applyStimulus("rf_full", 1'b0, 2'd0, 1'b0, 1'b0);
    doReset(1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("rf_after", 1'b0, 2'd0, 1'b0, 1'b1);
    end

    // Counter saturation: 17 deliveries on a 4-bit counter.
    for (int i = 0; i < 18; i++) begin
      applyStimulus("sat", 1'b1, 2'(i % 4), ^2'(i % 4), 1'b1);
    end
    applyStimulus("sat_end", 1'b0, 2'd0, 1'b0, 1'b1);
    checkOutput("sat_total", 16'(out_cnt), 16'hF);

`ifdef DECODER_PIPE_PARITY_EN
    // Parity: bad word travels as zero with error, good word decodes.
    doReset(1);
    applyStimulus("par_bad", 1'b1, 2'd1, 1'b0, 1'b1);
    applyStimulus("par_good", 1'b1, 2'd1, 1'b1, 1'b1);
    checkOutput("par_bad_err", 16'(out_err), 16'd1);
    applyStimulus("par_drain", 1'b0, 2'd0, 1'b0, 1'b1);
    checkOutput("par_good_hot", 16'(out_hot), 16'h2);
    applyStimulus("par_end", 1'b0, 2'd0, 1'b0, 1'b1);
`endif

    // Randomized traffic with random backpressure.
    doReset(1);
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus("rand_drain", 1'b0, 2'd0, 1'b0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
